ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). It drives the open-collector PS/2 clock and data lines through output-enables, checks the device ACK bit and reports completion. It sits beside the PS/2 scan-code receiver on the same keyboard pins; its tx_active output lets the receiver discard frames while a transmission is in progress.

---
 rtl/ps2_pkg.sv | 12 +
 rtl/ps2_line_filter.sv | 35 +++
 rtl/ps2_host_tx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 state encoding, keyboard command constants and frame builder shared by host tx and receiver
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} ps2_state_t;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RESP_ACK    = 8'hFA;
  localparam logic [7:0] RESP_BREAK  = 8'hF0;
  function automatic logic [9:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronise and debounce one PS/2 line, strobe on a filtered falling edge
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);
  localparam int CW = $clog2(FILTER_LEN) + 1;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_fall;
  // a new level is taken only after FILTER_LEN consecutive samples disagree with the current one
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) r_cnt <= '0;
      else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_fall  <= r_level;
      end else r_cnt <= r_cnt + 1'b1;
    end
  assign o_level = r_level;
  assign o_fall  = r_fall;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with ACK check and watchdog
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_active,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);
  import ps2_pkg::*;
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  ps2_state_t    r_state;
  logic [9:0]    r_shreg;
  logic [3:0]    r_bit_cnt;
  logic [IW-1:0] r_inh;
  logic [TW-1:0] r_wd;
  logic          r_clk_oe;
  logic          r_data_oe;
  logic          r_ack_bad;
  logic          r_done;
  logic          r_ack_err;
  logic          r_timeout_err;
  logic          w_clk_lvl;
  logic          w_clk_fall;
  logic          w_data_lvl;
  logic          w_watch;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst(rst), .i_pin(ps2_clk_in), .o_level(w_clk_lvl), .o_fall(w_clk_fall)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .rst(rst), .i_pin(ps2_data_in), .o_level(w_data_lvl), .o_fall()
  );

  assign w_watch = (r_state == SEND) || (r_state == ACK) || (r_state == WAIT_IDLE);

  // transfer sequencer; watchdog expiry overrides any device edge in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state       <= IDLE;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_inh         <= '0;
      r_wd          <= '0;
      r_clk_oe      <= 1'b0;
      r_data_oe     <= 1'b0;
      r_ack_bad     <= 1'b0;
      r_done        <= 1'b0;
      r_ack_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_ack_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      if (w_watch) r_wd <= r_wd + 1'b1;
      if (w_watch && r_wd == TW'(TIMEOUT_CYCLES - 1)) begin
        r_state       <= IDLE;
        r_clk_oe      <= 1'b0;
        r_data_oe     <= 1'b0;
        r_done        <= 1'b1;
        r_timeout_err <= 1'b1;
      end else
        case (r_state)
          IDLE:
            if (tx_valid) begin
              r_shreg   <= ps2_frame(tx_data);
              r_bit_cnt <= '0;
              r_inh     <= '0;
              r_ack_bad <= 1'b0;
              r_clk_oe  <= 1'b1;
              r_state   <= INHIBIT;
            end
          INHIBIT:
            if (r_inh == IW'(INHIBIT_CYCLES - 1)) begin
              r_data_oe <= 1'b1;
              r_state   <= RTS;
            end else r_inh <= r_inh + 1'b1;
          RTS: begin
            r_clk_oe <= 1'b0;
            r_wd     <= '0;
            r_state  <= SEND;
          end
          SEND:
            if (w_clk_fall) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_data_oe <= ~r_shreg[r_bit_cnt];
              if (r_bit_cnt == 4'd9) r_state <= ACK;
            end
          ACK:
            if (w_clk_fall) begin
              r_ack_bad <= w_data_lvl;
              r_state   <= WAIT_IDLE;
            end
          WAIT_IDLE:
            if (w_clk_lvl && w_data_lvl) begin
              r_done    <= 1'b1;
              r_ack_err <= r_ack_bad;
              r_state   <= IDLE;
            end
          default: r_state <= IDLE;
        endcase
    end

  assign tx_ready    = (r_state == IDLE);
  assign tx_active   = (r_state != IDLE);
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign done        = r_done;
  assign ack_err     = r_ack_err;
  assign timeout_err = r_timeout_err;
endmodule
